keypad_debounce_history: RTL and testbench

- Parametrised successor to the lab keypad debouncer.
- Accepts a raw key-pressed flag plus a key code from the keypad scanner and debounces both press and release with an internal cycle counter; no external free-running counter.
- Each confirmed press is shifted into a DEPTH-entry history register (entry 0 = newest).
- Sits between the keypad scanner and the seven-segment display driver.

---
 rtl/keypad_debounce_history_pkg.sv | 19 +
 rtl/keypad_debounce_history_timer.sv | 39 +++
 rtl/keypad_debounce_history.sv | 188 ++++++++++++++++++
 tb/tb_keypad_debounce_history.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/keypad_debounce_history_pkg.sv
// Shared types for the keypad debounce/history block.
// Holds the FSM state encoding and the default key-code width.
package keypad_pkg;

    // Debounce FSM states
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } kstate_t;

    // Default key-code width used by the scanner interface
    localparam int KEY_W_DEFAULT = 4;

    // Key code at the default width
    typedef logic [KEY_W_DEFAULT-1:0] key_t;

endpackage : keypad_pkg

// File: rtl/keypad_debounce_history_timer.sv
// Saturating stable-sample counter shared by debounce and auto-repeat.
//   clear=1, en=1 : count loads 1 (first stable sample already seen)
//   clear=1, en=0 : count loads 0
//   clear=0, en=1 : count increments, holding at N-1
// done is high while the count equals N-1, so the owner acts on the
// N-th enabled edge and the count never exceeds N-1.
module debounce_timer
    import keypad_pkg::*;
#(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic done
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] cnt;

    // Count enabled cycles, restart on clear, saturate at N-1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= en ? CW'(1) : '0;
        end else if (en && !done) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Terminal-count flag
    always_comb begin
        done = (cnt == CW'(N - 1));
    end

endmodule : debounce_timer

// File: rtl/keypad_debounce_history.sv
// Keypad debouncer with a shift-register history of confirmed keys.
// Sits between the keypad scanner and the seven-segment display driver.
// Both press and release must be stable for DEBOUNCE_CYCLES samples.
// Each confirmed press is shifted into hist at entry 0 (newest); the
// oldest entry falls off the top.
//
// Optional build macro KEYPAD_AUTO_REPEAT_EN: while a key stays held,
// the same code is recommitted every REPEAT_CYCLES cycles. Without the
// macro a held key commits exactly once and REPEAT_CYCLES is ignored.
module keypad_debounce_history
    import keypad_pkg::*;
#(
    parameter int KEY_W           = KEY_W_DEFAULT,
    parameter int DEPTH           = 2,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int REPEAT_CYCLES   = 500000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pressed,
    input  logic [KEY_W-1:0]       key_in,
    output logic [DEPTH*KEY_W-1:0] hist,
    output logic                   key_valid,
    output logic                   busy
);

    // Reject parameterisations the datapath cannot honour
    if (DEPTH < 1 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_param_err
        $error("keypad_debounce_history: DEPTH>=1, DEBOUNCE_CYCLES>=2, REPEAT_CYCLES>=1 required");
    end

    kstate_t              state;
    logic [KEY_W-1:0]     cand;
    logic                 same_key;
    logic                 deb_clear;
    logic                 deb_en;
    logic                 deb_done;
    logic                 rep_fire;
    logic [DEPTH*KEY_W-1:0] hist_shift;

    // Candidate comparison: a code change during PRESS_WAIT restarts the count
    always_comb begin
        same_key = (key_in == cand);
    end

    // Next history value: everything moves up one entry, cand lands in entry 0.
    // With DEPTH=1 the shift discards the old entry entirely.
    always_comb begin
        hist_shift               = hist << KEY_W;
        hist_shift[KEY_W-1:0]    = cand;
    end

    // Debounce counter control, mirroring the FSM transitions below
    always_comb begin
        deb_clear = 1'b1;
        deb_en    = 1'b0;
        case (state)
            IDLE: begin
                // First pressed sample counts as sample 1
                deb_en = pressed;
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    deb_en = 1'b0;
                end else if (!same_key) begin
                    deb_en = 1'b1;
                end else if (!deb_done) begin
                    deb_clear = 1'b0;
                    deb_en    = 1'b1;
                end
            end
            HELD: begin
                // First released sample counts as sample 1
                deb_en = !pressed;
            end
            RELEASE_WAIT: begin
                if (!pressed) begin
                    if (!deb_done) begin
                        deb_clear = 1'b0;
                        deb_en    = 1'b1;
                    end
                end
            end
            default: begin
                deb_en = 1'b0;
            end
        endcase
    end

    debounce_timer #(
        .N (DEBOUNCE_CYCLES)
    ) u_deb_timer (
        .clk   (clk),
        .reset (reset),
        .clear (deb_clear),
        .en    (deb_en),
        .done  (deb_done)
    );

`ifdef KEYPAD_AUTO_REPEAT_EN
    logic rep_active;
    logic rep_clear;
    logic rep_en;
    logic rep_done;

    // Repeat counter runs only while the key is held; it restarts after each
    // recommit and whenever the FSM leaves HELD.
    always_comb begin
        rep_active = (state == HELD) && pressed;
        rep_fire   = rep_active && rep_done;
        rep_clear  = !rep_active || rep_done;
        rep_en     = rep_active && !rep_done;
    end

    debounce_timer #(
        .N (REPEAT_CYCLES)
    ) u_rep_timer (
        .clk   (clk),
        .reset (reset),
        .clear (rep_clear),
        .en    (rep_en),
        .done  (rep_done)
    );
`else
    // Held keys never recommit
    always_comb begin
        rep_fire = 1'b0;
    end
`endif

    // Debounce FSM with registered history, pulse and busy outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= '0;
            hist      <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pressed) begin
                        state <= PRESS_WAIT;
                        busy  <= 1'b1;
                        cand  <= key_in;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed) begin
                        // Bounce: abandon the candidate, history untouched
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!same_key) begin
                        cand <= key_in;
                    end else if (deb_done) begin
                        hist      <= hist_shift;
                        key_valid <= 1'b1;
                        state     <= HELD;
                    end
                end
                HELD: begin
                    // Code changes while held are ignored; a new key needs a release
                    if (!pressed) begin
                        state <= RELEASE_WAIT;
                    end else if (rep_fire) begin
                        hist      <= hist_shift;
                        key_valid <= 1'b1;
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed) begin
                        // Release bounce: back to HELD without a new commit
                        state <= HELD;
                    end else if (deb_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : keypad_debounce_history

// File: tb/tb_keypad_debounce_history.sv
// Scoreboard bench for keypad_debounce_history (DEBOUNCE_CYCLES=4, DEPTH=2,
// KEY_W=4, REPEAT_CYCLES=8). Expected commits (edge number and history)
// are queued as stimulus is driven and popped on each key_valid pulse.
module tb_keypad_debounce_history;

    logic       clk = 1'b0;
    logic       reset;
    logic       pressed;
    logic [3:0] key_in;
    logic [7:0] hist;
    logic       key_valid;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int edges = 0;

    typedef struct {
        int         cyc;
        logic [7:0] h;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    always #5 clk = ~clk;

    keypad_debounce_history #(
        .KEY_W           (4),
        .DEPTH           (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pressed   (pressed),
        .key_in    (key_in),
        .hist      (hist),
        .key_valid (key_valid),
        .busy      (busy)
    );

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    // Drive pressed/key_in for n sampling edges (inputs change on negedge)
    task automatic hold(input logic p, input logic [3:0] k, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pressed = p;
            key_in  = k;
        end
    endtask

    // The edge following the last hold() step is the commit edge
    task automatic expect_next(input logic [7:0] h);
        sb.push_back('{cyc: edges + 1, h: h});
    endtask

    // Scoreboard consumer: every pulse must match the next queued commit
    always @(negedge clk) begin
        if (!reset && key_valid) begin
            if (sb.size() == 0) begin
                chk("kv_unexpected_pending", sb.size(), 1);
            end else begin
                cur = sb.pop_front();
                chk("kv_edge", edges, cur.cyc);
                chk("kv_hist", {24'h0, hist}, {24'h0, cur.h});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        pressed = 1'b0;
        key_in  = 4'h0;

        // Reset state
        repeat (10) @(negedge clk);
        chk("rst_hist", {24'h0, hist}, 32'h0);
        chk("rst_kv", {31'h0, key_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_hist", {24'h0, hist}, 32'h0);
        chk("post_rst_kv", {31'h0, key_valid}, 32'h0);
        chk("post_rst_busy", {31'h0, busy}, 32'h0);

        // Clean press F, release, clean press 6
        hold(1'b1, 4'hF, 4);
        expect_next(8'h0F);
        hold(1'b0, 4'h0, 4);
        @(negedge clk);
        chk("idle_after_release_busy", {31'h0, busy}, 32'h0);
        hold(1'b1, 4'h6, 4);
        expect_next(8'hF6);
        @(negedge clk);
        chk("held_busy", {31'h0, busy}, 32'h1);
        hold(1'b0, 4'h0, 4);

        // Press bounce: 2 edges, drop 1, then 4 stable edges
        hold(1'b1, 4'h3, 2);
        hold(1'b0, 4'h3, 1);
        @(negedge clk);
        chk("bounce_hist", {24'h0, hist}, 32'hF6);
        hold(1'b1, 4'h3, 4);
        expect_next(8'h63);
        hold(1'b0, 4'h0, 4);

        // Code change A->B during PRESS_WAIT restarts the count
        hold(1'b1, 4'hA, 2);
        hold(1'b1, 4'hB, 4);
        expect_next(8'h3B);
        hold(1'b0, 4'h0, 4);

        // Release bounce and code change while HELD
        hold(1'b1, 4'h5, 4);
        expect_next(8'hB5);
        hold(1'b0, 4'h5, 2);
        hold(1'b1, 4'h5, 3);
        hold(1'b1, 4'h9, 3);
        @(negedge clk);
        chk("held_change_busy", {31'h0, busy}, 32'h1);
        hold(1'b0, 4'h0, 4);
        @(negedge clk);
        chk("held_change_hist", {24'h0, hist}, 32'hB5);
        chk("held_release_busy", {31'h0, busy}, 32'h0);

        // Reset in PRESS_WAIT at cnt=3, then a normal press
        hold(1'b1, 4'h7, 3);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_rst_hist", {24'h0, hist}, 32'h0);
        chk("async_rst_busy", {31'h0, busy}, 32'h0);
        chk("async_rst_kv", {31'h0, key_valid}, 32'h0);
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        pressed = 1'b0;
        hold(1'b1, 4'h7, 4);
        expect_next(8'h07);
        hold(1'b0, 4'h0, 4);

`ifdef KEYPAD_AUTO_REPEAT_EN
        // Auto-repeat: pulses at commit, +8 and +16 cycles
        hold(1'b1, 4'h1, 4);
        begin
            int e0;
            e0 = edges + 1;
            sb.push_back('{cyc: e0,      h: 8'h71});
            sb.push_back('{cyc: e0 + 8,  h: 8'h11});
            sb.push_back('{cyc: e0 + 16, h: 8'h11});
        end
        hold(1'b1, 4'h1, 16);
        hold(1'b0, 4'h0, 4);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_keypad_debounce_history
